// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, drives the combinational IMEM and registers {pc, instr} for decode.
// Optional feature: define IFU_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Instr_Addr,
    input  logic [31:0] Instr_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        resume,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_pc
);

`ifdef IFU_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        TRAP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;
`endif

    // Fetch addresses are always word aligned; the low two bits are simply dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] target);
        return target & 32'hFFFF_FFFC;
    endfunction

`ifdef IFU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [31:0] target);
        return (target[1:0] != 2'b00);
    endfunction
`endif

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic        out_valid_r;
    logic        out_valid_s;
    logic [31:0] out_instr_r;
    logic [31:0] out_instr_s;
    logic [31:0] out_pc_r;
    logic [31:0] out_pc_s;
    logic        halted_r;
    logic        halted_s;
    logic        accept_s;
    logic        can_capture_s;
`ifdef IFU_MISALIGN_TRAP_EN
    logic        fault_r;
    logic        fault_s;
    logic [31:0] fault_pc_r;
    logic [31:0] fault_pc_s;
`endif

    assign accept_s      = out_valid_r & out_ready;
    assign can_capture_s = ~out_valid_r | out_ready;

    // Next-state, PC and output-stage decisions for every state.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        out_valid_s = out_valid_r;
        out_instr_s = out_instr_r;
        out_pc_s    = out_pc_r;
`ifdef IFU_MISALIGN_TRAP_EN
        fault_s     = fault_r;
        fault_pc_s  = fault_pc_r;
`endif
        case (state_r)
            BOOT: begin
                state_s = RUN;
            end
            RUN: begin
`ifdef IFU_MISALIGN_TRAP_EN
                if (redirect_valid && is_misaligned(redirect_pc)) begin
                    state_s     = TRAP;
                    fault_s     = 1'b1;
                    fault_pc_s  = redirect_pc;
                    out_valid_s = 1'b0;
                    out_instr_s = NOP_INSTR;
                end else
`endif
                if (redirect_valid) begin
                    // Redirect flushes the stage; a simultaneous halt still takes effect.
                    pc_s        = align_pc(redirect_pc);
                    out_valid_s = 1'b0;
                    out_instr_s = NOP_INSTR;
                    if (halt_req) begin
                        state_s = HALTED;
                    end else begin
                        state_s = RUN;
                    end
                end else if (halt_req) begin
                    state_s = HALTED;
                    if (accept_s) begin
                        out_valid_s = 1'b0;
                    end else begin
                        out_valid_s = out_valid_r;
                    end
                end else if (can_capture_s) begin
                    out_instr_s = Instr_rdata;
                    out_pc_s    = pc_r;
                    out_valid_s = 1'b1;
                    pc_s        = pc_r + 32'd4;
                end else begin
                    pc_s        = pc_r;
                    out_valid_s = out_valid_r;
                end
            end
            HALTED: begin
                // Only drain the pending output; no new fetch until resume.
                if (redirect_valid) begin
                    pc_s = align_pc(redirect_pc);
                end else begin
                    pc_s = pc_r;
                end
                if (accept_s) begin
                    out_valid_s = 1'b0;
                end else begin
                    out_valid_s = out_valid_r;
                end
                if (resume) begin
                    state_s = RUN;
                end else begin
                    state_s = HALTED;
                end
            end
`ifdef IFU_MISALIGN_TRAP_EN
            TRAP: begin
                state_s     = TRAP;
                out_valid_s = 1'b0;
            end
`endif
            default: begin
                state_s     = BOOT;
                out_valid_s = 1'b0;
                out_instr_s = NOP_INSTR;
            end
        endcase
        halted_s = (state_s == HALTED);
    end

    // State, PC and fetch output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= BOOT;
            pc_r        <= RESET_PC;
            out_valid_r <= 1'b0;
            out_instr_r <= NOP_INSTR;
            out_pc_r    <= 32'h0000_0000;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            out_valid_r <= out_valid_s;
            out_instr_r <= out_instr_s;
            out_pc_r    <= out_pc_s;
            halted_r    <= halted_s;
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    // Sticky trap record, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_r    <= 1'b0;
            fault_pc_r <= 32'h0000_0000;
        end else begin
            fault_r    <= fault_s;
            fault_pc_r <= fault_pc_s;
        end
    end

    assign fault    = fault_r;
    assign fault_pc = fault_pc_r;
`else
    assign fault    = 1'b0;
    assign fault_pc = 32'h0000_0000;
`endif

    assign Instr_Addr = pc_r;
    assign out_valid  = out_valid_r;
    assign out_instr  = out_instr_r;
    assign out_pc     = out_pc_r;
    assign halted     = halted_r;

endmodule
